// File: rtl/render_pkg.sv
// Purpose : shared types and constants for the sprite render queue and the display engine.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package render_pkg;

    // One sprite draw instruction, packed {magic, x, y, flags} (48 bits).
    typedef struct packed {
        logic [7:0]  magic;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  flags;
    } render_instr_t;

    // Instruction magic values.
    localparam logic [7:0] MAGIC_IDLE   = 8'h00;
    localparam logic [7:0] MAGIC_PLAYER = 8'h01;
    localparam logic [7:0] MAGIC_ENEMY  = 8'h02;
    localparam logic [7:0] MAGIC_BULLET = 8'h03;
    localparam logic [7:0] MAGIC_HEART  = 8'h04;
    // End-of-frame marker: the display engine renders everything before it.
    localparam logic [7:0] DO_RENDER    = 8'hFF;

    localparam logic [7:0] FLAG_FLIP_X  = 8'h01;

    // Register map (16-bit registers, word index).
    localparam logic [2:0] REG_STAGE_MF = 3'd0;
    localparam logic [2:0] REG_STAGE_X  = 3'd1;
    localparam logic [2:0] REG_STAGE_Y  = 3'd2;
    localparam logic [2:0] REG_COMMIT   = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_CONTROL  = 3'd5;

    // Head value shown while the queue is empty, so an idle consumer waits for the frame.
    localparam render_instr_t SENTINEL = '{magic: DO_RENDER, x: 16'h0, y: 16'h0, flags: 8'h0};

endpackage

// File: rtl/render_fifo_ram.sv
// Purpose : DEPTH x ENTRY_W register array, one write port, one combinational read port.
// Latency : write lands at the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the owner decides when writes are legal.
// Ports   : clk50, wr_en/wr_addr/wr_data (write port), rd_addr/rd_data (read port).
module render_fifo_ram #(
    parameter int DEPTH   = 32,
    parameter int ENTRY_W = 48,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk50,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Storage deliberately has no reset; emptiness is tracked by the owner's count.
    always_ff @(posedge clk50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/render_queue.sv
// Purpose : Avalon-MM slave that stages sprite instructions and queues them for the display engine.
// Latency : commit-to-head 1 cycle; readdata 1 cycle after read; pop takes effect at the sampling edge.
// Backpressure: commits into a full queue are dropped and set sticky overflow; pops while empty are ignored.
// Ports   : clk50/reset_n; Avalon chipselect/write/read/address/writedata/readdata;
//           render_queue_dout (head) and render_queue_pop_front (advance); frame_ready.
module render_queue
    import render_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int ENTRY_W = 48
) (
    input  logic               clk50,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic               write,
    input  logic               read,
    input  logic [2:0]         address,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic [ENTRY_W-1:0] render_queue_dout,
    input  logic               render_queue_pop_front,
    output logic               frame_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count, frames_pending;
    logic               overflow;
    logic [7:0]         stage_magic, stage_flags;
    logic [15:0]        stage_x, stage_y;
    render_instr_t      staged_instr;
    logic [ENTRY_W-1:0] head_data;

    logic wr_sel, do_commit, do_flush, do_clr_ov;
    logic empty, full, pop_ok, push_ok, push_drop;
    logic push_frame, pop_frame;
    logic [15:0] status_word;

    assign wr_sel    = chipselect & write;
    assign do_commit = wr_sel & (address == REG_COMMIT);
    assign do_flush  = wr_sel & (address == REG_CONTROL) & writedata[0];
    assign do_clr_ov = wr_sel & (address == REG_CONTROL) & writedata[1];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Flush wins over a simultaneous pop. A pop frees a slot, so a push into a
    // full queue in the same cycle still succeeds.
    assign pop_ok    = render_queue_pop_front & ~empty & ~do_flush;
    assign push_ok   = do_commit & (~full | pop_ok);
    assign push_drop = do_commit & full & ~pop_ok;

    always_comb begin
        staged_instr       = SENTINEL;
        staged_instr.magic = stage_magic;
        staged_instr.x     = stage_x;
        staged_instr.y     = stage_y;
        staged_instr.flags = stage_flags;
    end

    assign push_frame = push_ok & (stage_magic == DO_RENDER);
    assign pop_frame  = pop_ok & (head_data[ENTRY_W-1 -: 8] == DO_RENDER);

    render_fifo_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk50   (clk50),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (ENTRY_W'(staged_instr)),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    assign render_queue_dout = empty ? ENTRY_W'(SENTINEL) : head_data;
    assign frame_ready       = (frames_pending != '0);

    assign status_word = {overflow, full, empty, 6'(frames_pending), 7'(count)};

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            frames_pending <= '0;
            overflow       <= 1'b0;
            stage_magic    <= '0;
            stage_flags    <= '0;
            stage_x        <= '0;
            stage_y        <= '0;
            readdata       <= '0;
        end else begin
            if (wr_sel) begin
                case (address)
                    REG_STAGE_MF: begin
                        stage_magic <= writedata[15:8];
                        stage_flags <= writedata[7:0];
                    end
                    REG_STAGE_X: stage_x <= writedata;
                    REG_STAGE_Y: stage_y <= writedata;
                    default: ;
                endcase
            end

            readdata <= (chipselect & read & (address == REG_STATUS)) ? status_word : 16'h0;

            if (push_drop) begin
                overflow <= 1'b1;
            end else if (do_clr_ov) begin
                overflow <= 1'b0;
            end

            if (do_flush) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                count          <= '0;
                frames_pending <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);

                case ({push_ok, pop_ok})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase

                // Saturating up, never below zero; simultaneous inc/dec cancel.
                if (push_frame && !pop_frame && frames_pending != CW'(DEPTH)) begin
                    frames_pending <= frames_pending + CW'(1);
                end else if (pop_frame && !push_frame && frames_pending != '0) begin
                    frames_pending <= frames_pending - CW'(1);
                end
            end
        end
    end

endmodule
